// File: rtl/pwm_dc_ramp_pkg.sv
// Shared types and defaults for the duty-cycle ramp block.
// No logic; imported by the ramp top and its prescaler.
// Widths here must track the pwm block's i_DC width.
package pwm_dc_ramp_pkg;

    localparam int DW_DEF  = 16;
    localparam int PSW_DEF = 16;
    localparam logic [DW_DEF-1:0] RESET_DC_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STEP
    } ramp_state_t;

endpackage

// File: rtl/pwm_ramp_tick.sv
// Step-interval prescaler: counts enabled, unheld cycles and ticks on interval match.
// Latency: tick is combinational from the count, asserted on the (interval+1)-th counted cycle.
// Backpressure: hold freezes the count and suppresses tick; clr has priority over counting.
module pwm_ramp_tick #(
    parameter int PSW = pwm_dc_ramp_pkg::PSW_DEF
) (
    input  logic           i_wb_clk,
    input  logic           i_wb_rst,
    input  logic           clr,
    input  logic           en,
    input  logic           hold,
    input  logic [PSW-1:0] interval,
    output logic           tick
);

    logic [PSW-1:0] cnt;

    assign tick = en && !hold && (cnt == interval);

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst || clr || tick) begin
            cnt <= '0;
        end else if (en && !hold) begin
            cnt <= cnt + PSW'(1);
        end
    end

endmodule

// File: rtl/pwm_dc_ramp.sv
// Duty-cycle slew limiter feeding pwm i_DC/i_valid_DC: walks o_DC toward a clamped target.
// Latency: one step per interval+2 clocks; o_valid_DC/o_done are registered with the new o_DC.
// Backpressure: i_hold freezes prescaler and defers any pending step; no output change meanwhile.
module pwm_dc_ramp
    import pwm_dc_ramp_pkg::*;
#(
    parameter int              DW       = DW_DEF,
    parameter int              PSW      = PSW_DEF,
    parameter logic [DW-1:0]   DC_MAX   = {DW{1'b1}},
    parameter logic [DW-1:0]   RESET_DC = DW'(RESET_DC_DEF)
) (
    input  logic           i_wb_clk,
    input  logic           i_wb_rst,
    input  logic [DW-1:0]  i_target,
    input  logic           i_target_valid,
    input  logic [DW-1:0]  i_step,
    input  logic [PSW-1:0] i_interval,
    input  logic           i_hold,
    output logic [DW-1:0]  o_DC,
    output logic           o_valid_DC,
    output logic           o_busy,
    output logic           o_done
);

    ramp_state_t    state_q, state_d;
    logic [DW-1:0]  dc_q, tgt_q, step_q;
    logic [PSW-1:0] interval_q;
    logic           valid_q, done_q, done_d;
    logic           tick;

    logic [DW-1:0]        tgt_clamped;
    logic signed [DW:0]   diff;
    logic [DW:0]          mag;
    logic                 last_step;
    logic [DW-1:0]        stepped;
    logic                 do_step;
    logic [DW-1:0]        dc_next;
    logic                 changed;

    pwm_ramp_tick #(.PSW(PSW)) u_tick (
        .i_wb_clk (i_wb_clk),
        .i_wb_rst (i_wb_rst),
        .clr      (i_target_valid),
        .en       (state_q == ST_WAIT),
        .hold     (i_hold),
        .interval (interval_q),
        .tick     (tick)
    );

    assign tgt_clamped = (i_target > DC_MAX) ? DC_MAX : i_target;

    // Magnitude compare before add/sub rules out both overshoot and wrap.
    assign diff      = $signed({1'b0, tgt_q}) - $signed({1'b0, dc_q});
    assign mag       = diff[DW] ? (DW+1)'(-diff) : (DW+1)'(diff);
    assign last_step = (step_q == '0) || (mag <= {1'b0, step_q});
    assign stepped   = last_step ? tgt_q : (diff[DW] ? dc_q - step_q : dc_q + step_q);

    assign do_step = (state_q == ST_STEP) && !i_hold;
    assign dc_next = do_step ? stepped : dc_q;
    assign changed = do_step && (stepped != dc_q);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (i_target_valid && (tgt_clamped != dc_q)) state_d = ST_WAIT;
            ST_WAIT: if (tick) state_d = ST_STEP;
            ST_STEP: begin
                if (do_step) begin
                    state_d = last_step ? ST_IDLE : ST_WAIT;
                    done_d  = last_step && changed;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A retarget mid-ramp lets this cycle's update finish with the old values.
        if (i_target_valid && (state_q != ST_IDLE)) begin
            state_d = (tgt_clamped == dc_next) ? ST_IDLE : ST_WAIT;
            done_d  = changed && (tgt_clamped == dc_next);
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q    <= ST_IDLE;
            dc_q       <= RESET_DC;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            tgt_q      <= RESET_DC;
            step_q     <= '0;
            interval_q <= '0;
        end else begin
            state_q <= state_d;
            dc_q    <= dc_next;
            valid_q <= changed;
            done_q  <= done_d;
            if (i_target_valid) begin
                tgt_q      <= tgt_clamped;
                step_q     <= i_step;
                interval_q <= i_interval;
            end
        end
    end

    assign o_DC       = dc_q;
    assign o_valid_DC = valid_q;
    assign o_done     = done_q;
    assign o_busy     = (state_q != ST_IDLE);

endmodule
